branch_redirect_ctrl: RTL and testbench
=======================================

Name: branch_redirect_ctrl

Overview:
- Sequences PC redirection for the core.
- Arbitrates three redirect sources, in fixed priority, onto a single registered redirect channel to the IFU:
  - trap entry (highest)
  - mret
  - EX-stage branch/jump resolution from the branch unit (lowest)
- Holds the redirect with a valid/ready handshake until the IFU accepts it.
- Flushes wrong-path pipeline stages while the redirect is outstanding.
- Keeps saturating branch statistics counters.
- Sits between the EX/MEM stages (the requesters) and the IFU (the consumer). Static not-taken prediction is used, so every taken branch or jump is a redirect.

Parameters:
- PC_WIDTH, 32, width of all PC values
- CNT_WIDTH, 32, width of statistics counters

Ports:
- clk  input  1  core clock
- rst  input  1  asynchronous active-high reset
- ex_br_valid  input  1  EX holds a valid branch/jump instruction this cycle
- ex_take_branch  input  1  branch unit result: taken (jumps drive 1)
- ex_target_pc  input  PC_WIDTH  branch/jump target
- mret_req  input  1  MEM-stage mret request
- mret_pc  input  PC_WIDTH  mepc value
- trap_req  input  1  MEM-stage trap request
- trap_pc  input  PC_WIDTH  mtvec-derived handler address
- redirect_valid  output  1  redirect offered to the IFU
- redirect_pc  output  PC_WIDTH  redirect target
- redirect_ready  input  1  IFU accepts the redirect
- flush_if_id  output  1  kill the IF/ID register contents
- flush_id_ex  output  1  kill the ID/EX register contents
- branch_cnt  output  CNT_WIDTH  branches/jumps resolved
- taken_cnt  output  CNT_WIDTH  branches/jumps taken (i.e. redirects caused by EX)

Behaviour:
- Reset (async, rst=1), applied immediately and independent of clk:
  - state=IDLE
  - redirect_valid=0, redirect_pc=0
  - branch_cnt=0, taken_cnt=0
  - A redirect in flight is dropped; nothing is replayed after reset release.
- EX request ex_req = ex_br_valid & ex_take_branch. It is honoured only in IDLE; in HOLD, EX contents are wrong-path and ignored.
- Priority winner each cycle: trap_req > mret_req > ex_req.
- State IDLE:
  - If any request is present: latch the winner's PC into redirect_pc on the next clk edge, set redirect_valid=1, go to HOLD.
  - Latency from request to redirect_valid is 1 cycle.
  - flush_if_id=1 and flush_id_ex=1 combinationally in the request cycle.
- State HOLD:
  - redirect_valid=1 and redirect_pc stable unless overridden.
  - flush_if_id=1 and flush_id_ex=1 throughout.
  - redirect_ready=1: next state IDLE, redirect_valid=0.
  - trap_req in HOLD when the held source is not trap: replace redirect_pc with trap_pc and mark the source as trap. This applies even in a cycle where redirect_ready=1; the trap wins and the state stays HOLD for one more handshake.
  - mret_req in HOLD while holding an EX redirect: replace with mret_pc (same rule as above).
  - Same or lower priority request in HOLD: ignored.
- Held source is tracked in a 2-bit register (NONE/EX/MRET/TRAP) used for the override comparison.
- Simultaneous request and redirect_ready=1 in IDLE: redirect_ready is ignored in IDLE (no valid outstanding).
- Counters:
  - branch_cnt increments by 1 on ex_br_valid in IDLE only when no trap_req/mret_req is present that cycle (the branch is older-pipeline-killed otherwise).
  - taken_cnt increments under the same condition & ex_take_branch.
  - Both saturate at all-ones.
- PC values are passed through unmodified; no alignment check here (misalignment traps are raised upstream).

Decomposition:
- Shared core package/header:
  - redirect source encoding (REDIR_SRC_NONE=0, EX=1, MRET=2, TRAP=3)
  - state encoding (IDLE=0, HOLD=1)
  - the width macros used for PC/data
- One sub-module is natural: sat_counter (parameterised width, inc input, async reset), instantiated twice for the statistics.
- Arbitration and FSM stay in the top module.

Test Plan:
- Taken branch: ex_br_valid=1, ex_take_branch=1, ex_target_pc=0x80000100, redirect_ready tied 1 →
  - same cycle: flush_if_id=flush_id_ex=1
  - next cycle: redirect_valid=1, redirect_pc=0x80000100
  - following cycle: redirect_valid=0
  - branch_cnt=1, taken_cnt=1
- Not-taken branch: ex_take_branch=0 → no redirect, no flush; branch_cnt=1, taken_cnt=0.
- Backpressure: redirect_ready=0 for 5 cycles after a branch to 0x200 →
  - redirect_valid and pc=0x200 stable, flushes high all 5 cycles
  - further ex_req to 0x300 ignored, no count
  - ready=1 then accepts 0x200 and returns to IDLE
- Override: holding EX redirect 0x200, trap_req with trap_pc=0x80000000 arrives in the same cycle as redirect_ready=1 →
  - redirect_pc becomes 0x80000000, valid stays 1
  - accepted on the next ready
  - subsequent mret_req during that HOLD ignored
- Simultaneous in IDLE: trap_req, mret_req, ex_req together → redirect_pc=trap_pc; branch_cnt unchanged.
- Async reset mid-HOLD: assert rst between clock edges → redirect_valid=0, counters=0 immediately; after release, no redirect is reissued.

Source files
------------

// File: rtl/branch_redirect_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// branch_redirect_ctrl_pkg
//
// Shared definitions for the PC redirect controller:
//   - default PC / counter widths
//   - redirect source encoding (NONE/EX/MRET/TRAP), ordered by priority
//   - controller state encoding (IDLE/HOLD)
//   - helper that decides whether a new source may override a held one
// -----------------------------------------------------------------------------
package branch_redirect_ctrl_pkg;

    localparam int PC_W_DEFAULT  = 32;
    localparam int CNT_W_DEFAULT = 32;

    // The numeric order is the priority order, so a plain magnitude compare
    // tells whether one source outranks another.
    typedef enum logic [1:0] {
        REDIR_SRC_NONE = 2'd0,
        REDIR_SRC_EX   = 2'd1,
        REDIR_SRC_MRET = 2'd2,
        REDIR_SRC_TRAP = 2'd3
    } redir_src_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } redir_state_e;

    // True when req_src has strictly higher priority than held_src.
    function automatic logic src_outranks(input redir_src_e req_src,
                                          input redir_src_e held_src);
        return logic'(req_src > held_src);
    endfunction

endpackage : branch_redirect_ctrl_pkg

// File: rtl/branch_redirect_ctrl_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//
// Up-counter that sticks at all-ones instead of wrapping.
//
// Ports:
//   clk    in   clock
//   rst    in   asynchronous active-high reset, clears the count
//   inc    in   add one this cycle (ignored once saturated)
//   count  out  current count
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule : sat_counter

// File: rtl/branch_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// branch_redirect_ctrl
//
// Arbitrates trap entry, mret and taken EX branches/jumps onto one registered
// redirect channel to the IFU, holds it until the IFU accepts it, flushes the
// wrong-path IF/ID and ID/EX registers meanwhile, and counts branches.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   ex_br_valid, ex_take_branch,   EX branch/jump resolution
//   ex_target_pc
//   mret_req, mret_pc              MEM-stage mret and mepc
//   trap_req, trap_pc              MEM-stage trap and handler address
//   redirect_valid, redirect_pc,   redirect channel to the IFU
//   redirect_ready
//   flush_if_id, flush_id_ex       kill wrong-path pipeline registers
//   branch_cnt, taken_cnt          saturating statistics
// -----------------------------------------------------------------------------
module branch_redirect_ctrl
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int PC_WIDTH  = PC_W_DEFAULT,
    parameter int CNT_WIDTH = CNT_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ex_br_valid,
    input  logic                 ex_take_branch,
    input  logic [PC_WIDTH-1:0]  ex_target_pc,
    input  logic                 mret_req,
    input  logic [PC_WIDTH-1:0]  mret_pc,
    input  logic                 trap_req,
    input  logic [PC_WIDTH-1:0]  trap_pc,
    output logic                 redirect_valid,
    output logic [PC_WIDTH-1:0]  redirect_pc,
    input  logic                 redirect_ready,
    output logic                 flush_if_id,
    output logic                 flush_id_ex,
    output logic [CNT_WIDTH-1:0] branch_cnt,
    output logic [CNT_WIDTH-1:0] taken_cnt
);

    redir_state_e        state_q, state_d;
    redir_src_e          src_q,   src_d;
    logic [PC_WIDTH-1:0] pc_q,    pc_d;

    logic ex_req;
    logic any_req;
    logic flush;
    logic branch_inc;
    logic taken_inc;

    assign ex_req  = ex_br_valid & ex_take_branch;
    assign any_req = trap_req | mret_req | ex_req;

    // Next-state / redirect register logic.
    // In HOLD an override takes precedence over the handshake: if a trap (or
    // an mret over an EX redirect) arrives in the accept cycle, the new target
    // replaces the old one and must itself be accepted.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        pc_d    = pc_q;

        unique case (state_q)
            ST_IDLE: begin
                if (trap_req) begin
                    pc_d    = trap_pc;
                    src_d   = REDIR_SRC_TRAP;
                    state_d = ST_HOLD;
                end else if (mret_req) begin
                    pc_d    = mret_pc;
                    src_d   = REDIR_SRC_MRET;
                    state_d = ST_HOLD;
                end else if (ex_req) begin
                    pc_d    = ex_target_pc;
                    src_d   = REDIR_SRC_EX;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (trap_req && src_outranks(REDIR_SRC_TRAP, src_q)) begin
                    pc_d  = trap_pc;
                    src_d = REDIR_SRC_TRAP;
                end else if (mret_req && src_outranks(REDIR_SRC_MRET, src_q)) begin
                    pc_d  = mret_pc;
                    src_d = REDIR_SRC_MRET;
                end else if (redirect_ready) begin
                    src_d   = REDIR_SRC_NONE;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                src_d   = REDIR_SRC_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            src_q   <= REDIR_SRC_NONE;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            pc_q    <= pc_d;
        end
    end

    // Flush in the request cycle (combinational) and for the whole time the
    // redirect is outstanding.
    assign flush = (state_q == ST_HOLD) | ((state_q == ST_IDLE) & any_req);

    assign redirect_valid = (state_q == ST_HOLD);
    assign redirect_pc    = pc_q;
    assign flush_if_id    = flush;
    assign flush_id_ex    = flush;

    // A branch only counts when it is not killed by an older trap/mret and is
    // not wrong-path shadow behind an outstanding redirect.
    assign branch_inc = (state_q == ST_IDLE) & ex_br_valid & ~trap_req & ~mret_req;
    assign taken_inc  = branch_inc & ex_take_branch;

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_branch_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (branch_inc),
        .count (branch_cnt)
    );

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_taken_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (taken_inc),
        .count (taken_cnt)
    );

endmodule : branch_redirect_ctrl

// File: tb/tb_branch_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// tb_branch_redirect_ctrl
//
// Directed testbench for branch_redirect_ctrl. Inputs change 1 time unit after
// a rising edge; registered outputs are sampled there too, combinational
// flushes 1 unit later, well away from the active edge.
// -----------------------------------------------------------------------------
module tb_branch_redirect_ctrl;

    logic        clk;
    logic        rst;
    logic        ex_br_valid;
    logic        ex_take_branch;
    logic [31:0] ex_target_pc;
    logic        mret_req;
    logic [31:0] mret_pc;
    logic        trap_req;
    logic [31:0] trap_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic [31:0] branch_cnt;
    logic [31:0] taken_cnt;

    int assertCount;
    int failCount;

    branch_redirect_ctrl #(
        .PC_WIDTH  (32),
        .CNT_WIDTH (32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ex_br_valid    (ex_br_valid),
        .ex_take_branch (ex_take_branch),
        .ex_target_pc   (ex_target_pc),
        .mret_req       (mret_req),
        .mret_pc        (mret_pc),
        .trap_req       (trap_req),
        .trap_pc        (trap_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ready (redirect_ready),
        .flush_if_id    (flush_if_id),
        .flush_id_ex    (flush_id_ex),
        .branch_cnt     (branch_cnt),
        .taken_cnt      (taken_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic bv, input logic tk, input logic [31:0] tgt,
                                 input logic mr, input logic [31:0] mpc,
                                 input logic tr, input logic [31:0] tpc,
                                 input logic rdy);
        ex_br_valid    = bv;
        ex_take_branch = tk;
        ex_target_pc   = tgt;
        mret_req       = mr;
        mret_pc        = mpc;
        trap_req       = tr;
        trap_pc        = tpc;
        redirect_ready = rdy;
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic checkFlush(input string tag, input logic expected);
        #1;
        checkOutput({tag, "_flush_if_id"}, 32'(flush_if_id), 32'(expected));
        checkOutput({tag, "_flush_id_ex"}, 32'(flush_id_ex), 32'(expected));
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        rst = 1'b1;
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);

        // Reset values
        #1;
        checkOutput("rst_valid", 32'(redirect_valid), 32'd0);
        checkOutput("rst_pc", redirect_pc, 32'h0);
        checkOutput("rst_branch_cnt", branch_cnt, 32'd0);
        checkOutput("rst_taken_cnt", taken_cnt, 32'd0);
        stepClock();
        stepClock();
        rst = 1'b0;
        stepClock();

        // Taken branch with ready tied high
        applyStimulus(1, 1, 32'h8000_0100, 0, 32'h0, 0, 32'h0, 1);
        checkOutput("tk_valid_req_cycle", 32'(redirect_valid), 32'd0);
        checkFlush("tk_req", 1'b1);
        stepClock();
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1);
        checkOutput("tk_valid", 32'(redirect_valid), 32'd1);
        checkOutput("tk_pc", redirect_pc, 32'h8000_0100);
        checkOutput("tk_branch_cnt", branch_cnt, 32'd1);
        checkOutput("tk_taken_cnt", taken_cnt, 32'd1);
        stepClock();
        checkOutput("tk_valid_after", 32'(redirect_valid), 32'd0);
        checkFlush("tk_after", 1'b0);

        // Not-taken branch
        applyStimulus(1, 0, 32'h0000_0444, 0, 32'h0, 0, 32'h0, 1);
        checkFlush("nt", 1'b0);
        stepClock();
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1);
        checkOutput("nt_valid", 32'(redirect_valid), 32'd0);
        checkOutput("nt_branch_cnt", branch_cnt, 32'd2);
        checkOutput("nt_taken_cnt", taken_cnt, 32'd1);

        // Backpressure: branch to 0x200 held for 5 cycles, EX to 0x300 ignored
        applyStimulus(1, 1, 32'h0000_0200, 0, 32'h0, 0, 32'h0, 0);
        stepClock();
        for (int i = 0; i < 5; i++) begin
            if (i == 1) applyStimulus(1, 1, 32'h0000_0300, 0, 32'h0, 0, 32'h0, 0);
            else        applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
            checkOutput($sformatf("bp_valid_%0d", i), 32'(redirect_valid), 32'd1);
            checkOutput($sformatf("bp_pc_%0d", i), redirect_pc, 32'h0000_0200);
            checkFlush($sformatf("bp_%0d", i), 1'b1);
            stepClock();
        end
        checkOutput("bp_branch_cnt", branch_cnt, 32'd3);
        checkOutput("bp_taken_cnt", taken_cnt, 32'd2);
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1);
        checkOutput("bp_pc_accept", redirect_pc, 32'h0000_0200);
        stepClock();
        checkOutput("bp_valid_after", 32'(redirect_valid), 32'd0);
        checkFlush("bp_after", 1'b0);

        // Trap overrides a held EX redirect in the accept cycle
        applyStimulus(1, 1, 32'h0000_0200, 0, 32'h0, 0, 32'h0, 0);
        stepClock();
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 1, 32'h8000_0000, 1);
        checkOutput("ov_pc_before", redirect_pc, 32'h0000_0200);
        stepClock();
        applyStimulus(0, 0, 32'h0, 1, 32'h0000_1234, 0, 32'h0, 0);
        checkOutput("ov_valid", 32'(redirect_valid), 32'd1);
        checkOutput("ov_pc_trap", redirect_pc, 32'h8000_0000);
        stepClock();
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1);
        checkOutput("ov_mret_ignored_pc", redirect_pc, 32'h8000_0000);
        checkOutput("ov_mret_ignored_valid", 32'(redirect_valid), 32'd1);
        stepClock();
        checkOutput("ov_valid_after", 32'(redirect_valid), 32'd0);
        checkOutput("ov_branch_cnt", branch_cnt, 32'd4);
        checkOutput("ov_taken_cnt", taken_cnt, 32'd3);

        // mret overrides a held EX redirect
        applyStimulus(1, 1, 32'h0000_0700, 0, 32'h0, 0, 32'h0, 0);
        stepClock();
        applyStimulus(0, 0, 32'h0, 1, 32'h0000_0900, 0, 32'h0, 0);
        stepClock();
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1);
        checkOutput("mo_pc", redirect_pc, 32'h0000_0900);
        stepClock();
        checkOutput("mo_valid_after", 32'(redirect_valid), 32'd0);
        checkOutput("mo_branch_cnt", branch_cnt, 32'd5);

        // Trap, mret and EX together in IDLE
        applyStimulus(1, 1, 32'h0000_0600, 1, 32'h0000_0500, 1, 32'h8000_0040, 1);
        checkFlush("sim_req", 1'b1);
        stepClock();
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1);
        checkOutput("sim_valid", 32'(redirect_valid), 32'd1);
        checkOutput("sim_pc", redirect_pc, 32'h8000_0040);
        checkOutput("sim_branch_cnt", branch_cnt, 32'd5);
        checkOutput("sim_taken_cnt", taken_cnt, 32'd4);
        stepClock();
        checkOutput("sim_valid_after", 32'(redirect_valid), 32'd0);

        // Asynchronous reset in the middle of a HOLD
        applyStimulus(1, 1, 32'h0000_0A00, 0, 32'h0, 0, 32'h0, 0);
        stepClock();
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
        checkOutput("ar_valid_before", 32'(redirect_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("ar_valid", 32'(redirect_valid), 32'd0);
        checkOutput("ar_pc", redirect_pc, 32'h0);
        checkOutput("ar_branch_cnt", branch_cnt, 32'd0);
        checkOutput("ar_taken_cnt", taken_cnt, 32'd0);
        checkOutput("ar_flush", 32'(flush_if_id), 32'd0);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            stepClock();
            checkOutput($sformatf("ar_no_replay_%0d", i), 32'(redirect_valid), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule : tb_branch_redirect_ctrl
